// File: rtl/qam16_rx_demod_if.sv
// Sample-in / byte-out bundle for qam16_rx_demod; slave is the demodulator side,
// master is the sample source and byte consumer.
interface qam16_rx_demod_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic signed [15:0] din_i;
  logic signed [15:0] din_q;
  logic               din_valid;
  logic [7:0]         dout_byte;
  logic               dout_valid;
  logic               dout_ready;
  logic [LW-1:0]      fifo_level;
  logic               overflow;

  modport master (
    output din_i, din_q, din_valid, dout_ready,
    input  dout_byte, dout_valid, fifo_level, overflow
  );

  modport slave (
    input  din_i, din_q, din_valid, dout_ready,
    output dout_byte, dout_valid, fifo_level, overflow
  );
endinterface

// File: rtl/qam16_rx_demod.sv
// QAM-16 hard-decision demod: decimate, slice, pack nibble pairs into a show-ahead byte FIFO.
// Last sample to dout_valid is 2 cycles; input never stalls, full FIFO drops bytes (sticky overflow); QAM16_RX_GRAY_EN selects Gray demap.
module qam16_rx_demod #(
  parameter int AMP        = 8192,
  parameter int SPS        = 1,
  parameter int PHASE      = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  qam16_rx_demod_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(SPS - 1);
  localparam logic [CW-1:0] PH_SEL  = CW'(PHASE);
  localparam logic signed [17:0] THRESH = 18'(2 * AMP);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  function automatic logic [1:0] level(input logic signed [15:0] x);
    logic signed [17:0] xs;
    xs = {{2{x[15]}}, x};
    if (xs < -THRESH)     return 2'd0;
    else if (xs < 18'sd0) return 2'd1;
    else if (xs < THRESH) return 2'd2;
    else                  return 2'd3;
  endfunction

  function automatic logic [1:0] demap(input logic [1:0] idx);
`ifdef QAM16_RX_GRAY_EN
    return {idx[1], idx[1] ^ idx[0]};
`else
    return idx;
`endif
  endfunction

  logic [CW-1:0] ph;
  logic          take;
  logic          sym_vld;
  logic [3:0]    sym_nib;
  logic          half;
  logic [3:0]    hi_nib;
  logic          push;
  logic [7:0]    push_dat;

  assign take = bus.din_valid && (ph == PH_SEL);

  always_ff @(posedge clk) begin
    if (reset) begin
      ph <= '0;
    end else if (bus.din_valid) begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_vld <= 1'b0;
      sym_nib <= '0;
    end else begin
      sym_vld <= take;
      if (take) sym_nib <= {demap(level(bus.din_i)), demap(level(bus.din_q))};
    end
  end

  // half set means hi_nib holds the first nibble of the byte in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      half   <= 1'b0;
      hi_nib <= '0;
    end else if (sym_vld) begin
      if (!half) hi_nib <= sym_nib;
      half <= !half;
    end
  end

  assign push     = sym_vld && half;
  assign push_dat = {hi_nib, sym_nib};

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = !empty && bus.dout_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push && !push_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= push_dat;
  end

  assign bus.dout_valid = !empty;
  assign bus.dout_byte  = empty ? 8'h00 : mem[rd_ptr];
  assign bus.fifo_level = count;
  assign bus.overflow   = ovf;
endmodule

// File: doc/qam16_rx_demod.md
# qam16_rx_demod

Receive-side counterpart of the QAM-16 transmit chain (`top_tx`). It accepts signed 16-bit I/Q baseband samples, decimates them to one sample per symbol, hard-slices each symbol to a 4-bit nibble and packs nibble pairs into bytes. Bytes are buffered in a small FIFO and delivered downstream over a valid/ready handshake.

## Interface
- `AMP`, default 8192: unit constellation amplitude. Levels are ±AMP and ±3·AMP.
- `SPS`, default 1: input samples per symbol, 1..16.
- `PHASE`, default 0: sample index within a symbol that is sliced, 0..SPS-1.
- `FIFO_DEPTH`, default 8: output FIFO depth, a power of 2 and at least 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `din_i` in 16: signed I sample.
- `din_q` in 16: signed Q sample.
- `din_valid` in 1: sample qualifier. There is no backpressure; input is always accepted.
- `dout_byte` out 8: head-of-FIFO byte.
- `dout_valid` out 1: FIFO not empty.
- `dout_ready` in 1: consumer accepts `dout_byte` when both valid and ready are high.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag set when a byte is dropped because the FIFO is full.

## Operation
- **Reset.** One clock is synchronous and active-high, clock `clk` and reset `reset`. While `reset` is high at a rising edge:
  - the phase counter, slicer registers, nibble packer and FIFO pointers clear;
  - all outputs go to 0;
  - a partial nibble is discarded.
- **Decimator.**
  - The phase counter advances on each `din_valid` and wraps from SPS-1 to 0.
  - A sample is sliced when `din_valid` is high and counter == PHASE.
  - Cycles with `din_valid` low do not advance the counter.
- **Slicer.** THRESH = 2·AMP, signed comparison, applied to I and Q independently. Level index:
  - 0 if x < -THRESH;
  - 1 if -THRESH ≤ x < 0;
  - 2 if 0 ≤ x < THRESH;
  - 3 if x ≥ THRESH.
  - Consequences: x = 0 gives 2, x = THRESH gives 3, x = -THRESH gives 1. Saturated inputs (±32767/-32768) slice to 3/0.
- **Bit mapping.**
  - Index to 2 bits follows the configuration (see below).
  - nibble = {I bits, Q bits}, with I in nibble[3:2].
- **Packer.**
  - The first nibble of a pair is held in byte[7:4].
  - The second nibble completes the byte in [3:0], and the byte is pushed to the FIFO.
  - The packer toggles on each sliced symbol.
- **FIFO.**
  - Show-ahead: `dout_byte` = mem[rd_ptr] whenever `dout_valid` is high.
  - A pop occurs on `dout_valid && dout_ready`.
  - A push when full is dropped and sets `overflow`, unless a pop happens in the same cycle. In that case the push is accepted and the level is unchanged.
  - Push and pop in the same cycle when non-empty leave `fifo_level` unchanged.
  - A pop when empty is ignored.
  - There is no empty bypass.
- **Overflow.** `overflow` stays high until `reset`.

## Timing
- Slicer output is registered one edge after the accepted sample.
- The packer pushes on the following edge.
- Latency: final sample of a byte presented in cycle k, `dout_valid` high in cycle k+2 (FIFO previously empty), `fifo_level` incremented in k+2.
- Throughput: one symbol per cycle sustained when SPS = 1, so at most one byte every 2 cycles. The FIFO needs no more than one push per cycle.
- Reset asserted mid-byte: the held nibble is lost, and the next sliced symbol becomes the high nibble.
- `dout_byte` is stable while `dout_valid && !dout_ready`.

## Configuration
- `QAM16_RX_GRAY_EN` defined: Gray demap, index 0→00, 1→01, 2→11, 3→10. This matches the Gray-coded transmit mapper.
- Not defined: natural binary, index n→n[1:0]. All other behaviour is identical.

## Test plan
- **Gray decode.** With `QAM16_RX_GRAY_EN`, SPS=1, apply (I,Q) = (-24576, 24576) then (8192, -8192) → byte 0x2D, `dout_valid` 2 cycles after the second sample. Without the macro, the same stimulus → 0x39.
- **Threshold edges.** Apply (I,Q) = (16384, 0) then (-16384, -16385) → indices (3,2),(1,0). Gray → 0xB4.
- **Decimation.** SPS=4, PHASE=2, 8 valid samples with `din_valid` gaps, where only samples 2 and 6 carry (24576, 24576) → one byte 0xAA (Gray). The other samples are ignored.
- **Backpressure and overflow.** Hold `dout_ready`=0 and push 9 bytes with FIFO_DEPTH=8 → `fifo_level`=8, `overflow`=1, 9th byte lost. Then raise ready → the first 8 bytes are read in order.
- **Full with simultaneous pop.** With the FIFO full, pop in the same cycle as a push → `fifo_level` stays 8 and `overflow` stays 0.
- **Mid-byte reset.** After one symbol, assert `reset` for 1 cycle → all outputs 0. The next two symbols form a correct byte.
